// File: rtl/cpu_pkg.sv
// Shared opcode, step and instruction-class definitions for the hardwired control unit.
package cpu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD = OP_ADD;

    typedef enum logic [3:0] {T0, T1, T2, T3, T4, T5, T6, T7, HALT} step_e;

    typedef enum logic [3:0] {
        CL_ALU3, CL_IMM, CL_UNARY, CL_MULDIV, CL_LD, CL_LDI, CL_ST, CL_BR,
        CL_JR, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT, CL_ILLEGAL
    } op_class_e;

    // Groups opcodes that share the same step sequence.
    function automatic op_class_e op_class(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL:       op_class = CL_ALU3;
            OP_ADDI, OP_ANDI, OP_ORI:              op_class = CL_IMM;
            OP_NEG, OP_NOT:                        op_class = CL_UNARY;
            OP_MUL, OP_DIV:                        op_class = CL_MULDIV;
            OP_LD:                                 op_class = CL_LD;
            OP_LDI:                                op_class = CL_LDI;
            OP_ST:                                 op_class = CL_ST;
            OP_BR:                                 op_class = CL_BR;
            OP_JR:                                 op_class = CL_JR;
            OP_IN:                                 op_class = CL_IN;
            OP_OUT:                                op_class = CL_OUT;
            OP_MFHI:                               op_class = CL_MFHI;
            OP_MFLO:                               op_class = CL_MFLO;
            OP_NOP:                                op_class = CL_NOP;
            OP_HALT:                               op_class = CL_HALT;
            default:                               op_class = CL_ILLEGAL;
        endcase
    endfunction

    function automatic logic [4:0] imm_alu(input logic [4:0] op);
        case (op)
            OP_ADDI: imm_alu = ALU_ADD;
            OP_ANDI: imm_alu = OP_AND;
            OP_ORI:  imm_alu = OP_OR;
            default: imm_alu = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/seq_wait_counter.sv
// Loadable 3-bit down-counter that stretches the memory-read steps.
module seq_wait_counter (
    input  logic       clk,
    input  logic       clr,
    input  logic       load,
    input  logic       dec,
    input  logic [2:0] load_val,
    output logic       zero
);

    logic [2:0] count_q;
    logic [2:0] count_d;

    // Next count: load wins over decrement; saturates at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != 3'd0)) begin
            count_d = count_q - 3'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (clr) begin
            count_q <= 3'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == 3'd0);

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer driving the Phase 1 datapath strobes.
// Optional SEQ_SINGLE_STEP_EN adds a step input that gates each instruction in T0.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int MEM_WAIT = 1
) (
    input  logic        clk,
    input  logic        clr,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic        step,
`endif
    input  logic [31:0] ir,
    input  logic        con,
    output logic        run,
    output logic        illegal,
    output logic        Gra, Grb, Grc, Rin, Rout, BAout, RYin,
    output logic        MARin, HIin, LOin, Zhighin, Zlowin, PCin, IRin, MDRin,
    output logic        HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Cout, InPort_read,
    output logic        OutPort_write, read, pc_increment, memoryRead, memoryWrite,
    output logic [4:0]  alu_control
);

    localparam logic [2:0] WAIT_LOAD = 3'(MEM_WAIT - 1);

    step_e       state_q;
    step_e       state_d;
    logic [4:0]  opcode_s;
    op_class_e   class_s;
    logic        go_s;
    logic        cnt_load_s;
    logic        cnt_dec_s;
    logic        cnt_zero_s;
    logic        unused_ir_s;

    assign opcode_s    = ir[31:27];
    assign class_s     = op_class(opcode_s);
    assign unused_ir_s = ^ir[26:0];

`ifdef SEQ_SINGLE_STEP_EN
    assign go_s = step;
`else
    assign go_s = 1'b1;
`endif

    seq_wait_counter u_wait (
        .clk      (clk),
        .clr      (clr),
        .load     (cnt_load_s),
        .dec      (cnt_dec_s),
        .load_val (WAIT_LOAD),
        .zero     (cnt_zero_s)
    );

    // Step register.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= T0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next step and strobe decode; everything stays 0 while clr is high.
    always_comb begin
        state_d = state_q;
        cnt_load_s = 1'b0;  cnt_dec_s = 1'b0;
        run = 1'b1;         illegal = 1'b0;
        Gra = 1'b0;  Grb = 1'b0;  Grc = 1'b0;  Rin = 1'b0;  Rout = 1'b0;  BAout = 1'b0;  RYin = 1'b0;
        MARin = 1'b0;  HIin = 1'b0;  LOin = 1'b0;  Zhighin = 1'b0;  Zlowin = 1'b0;
        PCin = 1'b0;  IRin = 1'b0;  MDRin = 1'b0;
        HIout = 1'b0;  LOout = 1'b0;  Zhighout = 1'b0;  Zlowout = 1'b0;  PCout = 1'b0;
        MDRout = 1'b0;  Cout = 1'b0;  InPort_read = 1'b0;  OutPort_write = 1'b0;
        read = 1'b0;  pc_increment = 1'b0;  memoryRead = 1'b0;  memoryWrite = 1'b0;
        alu_control = 5'd0;
        if (clr) begin
            state_d = T0;
        end else begin
            case (state_q)
                T0: begin
                    if (go_s) begin
                        PCout = 1'b1;  MARin = 1'b1;  pc_increment = 1'b1;
                        cnt_load_s = 1'b1;
                        state_d = T1;
                    end else begin
                        state_d = T0;
                    end
                end
                T1: begin
                    memoryRead = 1'b1;  read = 1'b1;  MDRin = 1'b1;
                    if (cnt_zero_s) begin
                        state_d = T2;
                    end else begin
                        cnt_dec_s = 1'b1;
                    end
                end
                T2: begin
                    MDRout = 1'b1;  IRin = 1'b1;  state_d = T3;
                end
                T3: begin
                    state_d = T4;
                    case (class_s)
                        CL_ALU3, CL_IMM: begin Grb = 1'b1;  Rout = 1'b1;  RYin = 1'b1; end
                        CL_UNARY:  begin Grb = 1'b1;  Rout = 1'b1;  alu_control = opcode_s;  Zlowin = 1'b1; end
                        CL_MULDIV: begin Gra = 1'b1;  Rout = 1'b1;  RYin = 1'b1; end
                        CL_LD, CL_LDI, CL_ST: begin Grb = 1'b1;  BAout = 1'b1;  Rout = 1'b1;  RYin = 1'b1; end
                        CL_BR:     begin Gra = 1'b1;  Rout = 1'b1; end
                        CL_JR:     begin Gra = 1'b1;  Rout = 1'b1;  PCin = 1'b1;  state_d = T0; end
                        CL_IN:     begin InPort_read = 1'b1;  Gra = 1'b1;  Rin = 1'b1;  state_d = T0; end
                        CL_OUT:    begin Gra = 1'b1;  Rout = 1'b1;  OutPort_write = 1'b1;  state_d = T0; end
                        CL_MFHI:   begin HIout = 1'b1;  Gra = 1'b1;  Rin = 1'b1;  state_d = T0; end
                        CL_MFLO:   begin LOout = 1'b1;  Gra = 1'b1;  Rin = 1'b1;  state_d = T0; end
                        CL_NOP:    begin state_d = T0; end
                        CL_HALT:   begin state_d = HALT; end
                        default:   begin illegal = 1'b1;  state_d = T0; end
                    endcase
                end
                T4: begin
                    state_d = T5;
                    case (class_s)
                        CL_ALU3:   begin Grc = 1'b1;  Rout = 1'b1;  alu_control = opcode_s;  Zlowin = 1'b1; end
                        CL_IMM:    begin Cout = 1'b1;  alu_control = imm_alu(opcode_s);  Zlowin = 1'b1; end
                        CL_UNARY:  begin Zlowout = 1'b1;  Gra = 1'b1;  Rin = 1'b1;  state_d = T0; end
                        CL_MULDIV: begin
                            Grb = 1'b1;  Rout = 1'b1;  alu_control = opcode_s;
                            Zlowin = 1'b1;  Zhighin = 1'b1;
                        end
                        CL_LD, CL_LDI, CL_ST: begin Cout = 1'b1;  alu_control = ALU_ADD;  Zlowin = 1'b1; end
                        CL_BR:     begin PCout = 1'b1;  RYin = 1'b1; end
                        default:   begin state_d = T0; end
                    endcase
                end
                T5: begin
                    state_d = T0;
                    case (class_s)
                        CL_ALU3, CL_IMM, CL_LDI: begin Zlowout = 1'b1;  Gra = 1'b1;  Rin = 1'b1; end
                        CL_MULDIV: begin Zlowout = 1'b1;  LOin = 1'b1;  state_d = T6; end
                        CL_LD:     begin Zlowout = 1'b1;  MARin = 1'b1;  cnt_load_s = 1'b1;  state_d = T6; end
                        CL_ST:     begin Zlowout = 1'b1;  MARin = 1'b1;  state_d = T6; end
                        CL_BR:     begin Cout = 1'b1;  alu_control = ALU_ADD;  Zlowin = 1'b1;  state_d = T6; end
                        default:   begin state_d = T0; end
                    endcase
                end
                T6: begin
                    state_d = T0;
                    case (class_s)
                        CL_MULDIV: begin Zhighout = 1'b1;  HIin = 1'b1; end
                        CL_LD: begin
                            memoryRead = 1'b1;  read = 1'b1;  MDRin = 1'b1;
                            if (cnt_zero_s) begin
                                state_d = T7;
                            end else begin
                                cnt_dec_s = 1'b1;  state_d = T6;
                            end
                        end
                        CL_ST: begin Gra = 1'b1;  Rout = 1'b1;  MDRin = 1'b1;  state_d = T7; end
                        CL_BR: begin
                            if (con) begin
                                Zlowout = 1'b1;  PCin = 1'b1;
                            end else begin
                                Zlowout = 1'b0;  PCin = 1'b0;
                            end
                        end
                        default: begin state_d = T0; end
                    endcase
                end
                T7: begin
                    state_d = T0;
                    case (class_s)
                        CL_LD:   begin MDRout = 1'b1;  Gra = 1'b1;  Rin = 1'b1; end
                        CL_ST:   begin memoryWrite = 1'b1; end
                        default: begin state_d = T0; end
                    endcase
                end
                HALT: begin
                    run = 1'b0;  state_d = HALT;
                end
                default: begin
                    state_d = T0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: two sequencers (memory wait 1 and 3) against a step-list reference model.
module tb_control_sequencer;

    typedef logic [34:0] vec_t;   // {run, alu_control[4:0], strobes[28:0]}

    localparam int S_GRA = 0,  S_GRB = 1,  S_GRC = 2,  S_RIN = 3,  S_ROUT = 4,  S_BAOUT = 5;
    localparam int S_RYIN = 6, S_MARIN = 7, S_HIIN = 8, S_LOIN = 9, S_ZHIN = 10, S_ZLIN = 11;
    localparam int S_PCIN = 12, S_IRIN = 13, S_MDRIN = 14, S_HIOUT = 15, S_LOOUT = 16;
    localparam int S_ZHOUT = 17, S_ZLOUT = 18, S_PCOUT = 19, S_MDROUT = 20, S_COUT = 21;
    localparam int S_INRD = 22, S_OUTWR = 23, S_READ = 24, S_PCINC = 25, S_MEMRD = 26;
    localparam int S_MEMWR = 27, S_ILL = 28;

    localparam vec_t DRV = (35'd1 << S_ROUT) | (35'd1 << S_HIOUT) | (35'd1 << S_LOOUT) |
                           (35'd1 << S_ZHOUT) | (35'd1 << S_ZLOUT) | (35'd1 << S_PCOUT) |
                           (35'd1 << S_MDROUT) | (35'd1 << S_COUT) | (35'd1 << S_INRD);

    logic        clk;
    logic        clr;
    logic [31:0] ir;
    logic        con;
    int          tests;
    int          fails;
    vec_t        exp0[$];
    vec_t        exp1[$];

    wire [28:0] s_w   [2];
    wire [4:0]  alu_w [2];
    wire        run_w [2];
    wire [34:0] obs   [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    genvar g;
    for (g = 0; g < 2; g++) begin : g_dut
        control_sequencer #(.MEM_WAIT(g == 0 ? 1 : 3)) u_dut (
            .clk(clk), .clr(clr),
`ifdef SEQ_SINGLE_STEP_EN
            .step(1'b1),
`endif
            .ir(ir), .con(con), .run(run_w[g]), .illegal(s_w[g][S_ILL]),
            .Gra(s_w[g][S_GRA]), .Grb(s_w[g][S_GRB]), .Grc(s_w[g][S_GRC]), .Rin(s_w[g][S_RIN]),
            .Rout(s_w[g][S_ROUT]), .BAout(s_w[g][S_BAOUT]), .RYin(s_w[g][S_RYIN]),
            .MARin(s_w[g][S_MARIN]), .HIin(s_w[g][S_HIIN]), .LOin(s_w[g][S_LOIN]),
            .Zhighin(s_w[g][S_ZHIN]), .Zlowin(s_w[g][S_ZLIN]), .PCin(s_w[g][S_PCIN]),
            .IRin(s_w[g][S_IRIN]), .MDRin(s_w[g][S_MDRIN]), .HIout(s_w[g][S_HIOUT]),
            .LOout(s_w[g][S_LOOUT]), .Zhighout(s_w[g][S_ZHOUT]), .Zlowout(s_w[g][S_ZLOUT]),
            .PCout(s_w[g][S_PCOUT]), .MDRout(s_w[g][S_MDROUT]), .Cout(s_w[g][S_COUT]),
            .InPort_read(s_w[g][S_INRD]), .OutPort_write(s_w[g][S_OUTWR]), .read(s_w[g][S_READ]),
            .pc_increment(s_w[g][S_PCINC]), .memoryRead(s_w[g][S_MEMRD]),
            .memoryWrite(s_w[g][S_MEMWR]), .alu_control(alu_w[g])
        );
        assign obs[g] = {run_w[g], alu_w[g], s_w[g]};
    end

    function automatic logic [28:0] b(input int i);
        b = 29'd1 << i;
    endfunction

    function automatic vec_t mk(input logic [28:0] m, input logic [4:0] alu, input logic r);
        mk = {r, alu, m};
    endfunction

    // Reference model: the list of per-cycle strobe sets one instruction should produce.
    task automatic build(input int d, input int w, input logic [4:0] op, input logic c);
        vec_t q[$];
        int   k;
        logic [28:0] t3_mem;
        k = int'(op);
        t3_mem = b(S_GRB) | b(S_BAOUT) | b(S_ROUT) | b(S_RYIN);
        q.push_back(mk(b(S_PCOUT) | b(S_MARIN) | b(S_PCINC), 5'd0, 1'b1));
        repeat (w) q.push_back(mk(b(S_MEMRD) | b(S_READ) | b(S_MDRIN), 5'd0, 1'b1));
        q.push_back(mk(b(S_MDROUT) | b(S_IRIN), 5'd0, 1'b1));
        if (k >= 3 && k <= 11) begin
            q.push_back(mk(b(S_GRB) | b(S_ROUT) | b(S_RYIN), 5'd0, 1'b1));
            q.push_back(mk(b(S_GRC) | b(S_ROUT) | b(S_ZLIN), op, 1'b1));
            q.push_back(mk(b(S_ZLOUT) | b(S_GRA) | b(S_RIN), 5'd0, 1'b1));
        end else if (k >= 12 && k <= 14) begin
            q.push_back(mk(b(S_GRB) | b(S_ROUT) | b(S_RYIN), 5'd0, 1'b1));
            q.push_back(mk(b(S_COUT) | b(S_ZLIN), (k == 12) ? 5'd3 : (k == 13) ? 5'd5 : 5'd6, 1'b1));
            q.push_back(mk(b(S_ZLOUT) | b(S_GRA) | b(S_RIN), 5'd0, 1'b1));
        end else if (k == 17 || k == 18) begin
            q.push_back(mk(b(S_GRB) | b(S_ROUT) | b(S_ZLIN), op, 1'b1));
            q.push_back(mk(b(S_ZLOUT) | b(S_GRA) | b(S_RIN), 5'd0, 1'b1));
        end else if (k == 15 || k == 16) begin
            q.push_back(mk(b(S_GRA) | b(S_ROUT) | b(S_RYIN), 5'd0, 1'b1));
            q.push_back(mk(b(S_GRB) | b(S_ROUT) | b(S_ZLIN) | b(S_ZHIN), op, 1'b1));
            q.push_back(mk(b(S_ZLOUT) | b(S_LOIN), 5'd0, 1'b1));
            q.push_back(mk(b(S_ZHOUT) | b(S_HIIN), 5'd0, 1'b1));
        end else if (k <= 2) begin
            q.push_back(mk(t3_mem, 5'd0, 1'b1));
            q.push_back(mk(b(S_COUT) | b(S_ZLIN), 5'd3, 1'b1));
            if (k == 1) begin
                q.push_back(mk(b(S_ZLOUT) | b(S_GRA) | b(S_RIN), 5'd0, 1'b1));
            end else if (k == 0) begin
                q.push_back(mk(b(S_ZLOUT) | b(S_MARIN), 5'd0, 1'b1));
                repeat (w) q.push_back(mk(b(S_MEMRD) | b(S_READ) | b(S_MDRIN), 5'd0, 1'b1));
                q.push_back(mk(b(S_MDROUT) | b(S_GRA) | b(S_RIN), 5'd0, 1'b1));
            end else begin
                q.push_back(mk(b(S_ZLOUT) | b(S_MARIN), 5'd0, 1'b1));
                q.push_back(mk(b(S_GRA) | b(S_ROUT) | b(S_MDRIN), 5'd0, 1'b1));
                q.push_back(mk(b(S_MEMWR), 5'd0, 1'b1));
            end
        end else if (k == 19) begin
            q.push_back(mk(b(S_GRA) | b(S_ROUT), 5'd0, 1'b1));
            q.push_back(mk(b(S_PCOUT) | b(S_RYIN), 5'd0, 1'b1));
            q.push_back(mk(b(S_COUT) | b(S_ZLIN), 5'd3, 1'b1));
            q.push_back(mk(c ? (b(S_ZLOUT) | b(S_PCIN)) : 29'd0, 5'd0, 1'b1));
        end else if (k == 20) q.push_back(mk(b(S_GRA) | b(S_ROUT) | b(S_PCIN), 5'd0, 1'b1));
        else if (k == 22) q.push_back(mk(b(S_INRD) | b(S_GRA) | b(S_RIN), 5'd0, 1'b1));
        else if (k == 23) q.push_back(mk(b(S_GRA) | b(S_ROUT) | b(S_OUTWR), 5'd0, 1'b1));
        else if (k == 24) q.push_back(mk(b(S_HIOUT) | b(S_GRA) | b(S_RIN), 5'd0, 1'b1));
        else if (k == 25) q.push_back(mk(b(S_LOOUT) | b(S_GRA) | b(S_RIN), 5'd0, 1'b1));
        else if (k == 26) q.push_back(mk(29'd0, 5'd0, 1'b1));
        else if (k == 27) begin
            q.push_back(mk(29'd0, 5'd0, 1'b1));
            repeat (20) q.push_back(mk(29'd0, 5'd0, 1'b0));
        end else q.push_back(mk(b(S_ILL), 5'd0, 1'b1));
        if (k != 27) q.push_back(mk(b(S_PCOUT) | b(S_MARIN) | b(S_PCINC), 5'd0, 1'b1));
        if (d == 0) exp0 = q;
        else exp1 = q;
    endtask

    task automatic check(input int d, input vec_t e, input string tag);
        vec_t o;
        o = obs[d];
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s dut%0d got %h expected %h", tag, d, o, e);
        end
        tests++;
        assert ($countones(o & DRV) <= 1) else begin
            fails++;
            $error("FAIL %s_bus dut%0d got %h expected at most one bus driver", tag, d, o);
        end
    endtask

    // One clr cycle, then walk both expected lists (optionally cut short to abort mid-instruction).
    task automatic run_instr(input logic [31:0] ir_v, input logic c, input int limit, input string name);
        int n;
        ir  = ir_v;
        con = c;
        build(0, 1, ir_v[31:27], c);
        build(1, 3, ir_v[31:27], c);
        clr = 1'b1;
        @(negedge clk);
        check(0, mk(29'd0, 5'd0, 1'b1), {name, "_clr"});
        check(1, mk(29'd0, 5'd0, 1'b1), {name, "_clr"});
        @(posedge clk); #1;
        clr = 1'b0;
        n = (exp0.size() > exp1.size()) ? exp0.size() : exp1.size();
        if (limit >= 0 && limit < n) n = limit;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i < exp0.size()) check(0, exp0[i], $sformatf("%s_c%0d", name, i));
            if (i < exp1.size()) check(1, exp1[i], $sformatf("%s_c%0d", name, i));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        clr = 1'b1;
        ir  = 32'd0;
        con = 1'b0;
        @(posedge clk); #1;
        run_instr(32'h18918000, 1'b0, -1, "add");
        run_instr(32'h00900054, 1'b0, -1, "ld");
        run_instr(32'h98800000, 1'b0, -1, "br_con0");
        run_instr(32'h98800000, 1'b1, -1, "br_con1");
        run_instr(32'h80910000, 1'b0, -1, "mul");
        run_instr(32'h10900054, 1'b0, 4, "st_abort_t4");
        run_instr(32'h60900007, 1'b0, -1, "addi");
        run_instr(32'hD8000000, 1'b0, -1, "halt");
        run_instr(32'hA8000000, 1'b0, -1, "illegal");
        for (int r = 0; r < 60; r++) begin
            logic [31:0] rir;
            logic        rc;
            int          lim;
            rir = $urandom;
            rc  = 1'($urandom_range(0, 1));
            lim = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 8)) : -1;
            run_instr(rir, rc, lim, $sformatf("rnd%0d_op%0d", r, rir[31:27]));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
